// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port 16-bit word memory between the fx68k CPU bus and the
// ESP32 SPI loader word port, and generates the CPU's DTACKn. This lets the
// OSD/loader read and write RAM while the CPU keeps running.
//
// The CPU normally has priority. A saturating starvation counter tracks how
// long an SPI request has been waiting. Once the counter reaches
// SPI_STARVE_LIMIT, the SPI request wins the next arbitration, even if a CPU
// access is also pending.
//
// Parameters
//   ADDR_BITS         word-address width (CPU byte address bits [ADDR_BITS:1])
//   SPI_STARVE_LIMIT  cycles a pending SPI request waits before it beats a
//                     pending CPU access (1..255)
//
// Configuration macro
//   MEM_ARB_SPI_READ_EN
//     defined   : SPI reads strobe mem_re and return data on spi_rdata.
//     undefined : SPI reads are still granted and acked, but mem_re is not
//                 strobed and spi_rdata stays 0. The read path is not built.
//
// Ports
//   clk, reset              single clock; synchronous active-high reset
//   cpu_as_n, cpu_rw        CPU address strobe, 1 = read / 0 = write
//   cpu_uds_n, cpu_lds_n    CPU upper/lower data strobes
//   cpu_a, cpu_dout         CPU word address and write data
//   cpu_din, cpu_dtack_n    registered read data and DTACKn back to the CPU
//   spi_req, spi_we         SPI level request and direction (1 = write)
//   spi_addr, spi_wdata     SPI word address and write data
//   spi_ack, spi_rdata      one-cycle completion pulse and read data
//   mem_addr, mem_we,       memory command. Address, byte enables and data
//   mem_re, mem_be,         hold their last value between accesses; only the
//   mem_wdata               strobes are meaningful.
//   mem_rdata               memory read data, valid one cycle after mem_re
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_BITS        = 23,
    parameter int SPI_STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,

    // fx68k CPU bus
    input  logic                 cpu_as_n,
    input  logic                 cpu_rw,
    input  logic                 cpu_uds_n,
    input  logic                 cpu_lds_n,
    input  logic [ADDR_BITS-1:0] cpu_a,
    input  logic [15:0]          cpu_dout,
    output logic [15:0]          cpu_din,
    output logic                 cpu_dtack_n,

    // ESP32 SPI loader word port
    input  logic                 spi_req,
    input  logic                 spi_we,
    input  logic [ADDR_BITS-1:0] spi_addr,
    input  logic [15:0]          spi_wdata,
    output logic                 spi_ack,
    output logic [15:0]          spi_rdata,

    // Single-port memory
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [1:0]           mem_be,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ACC  = 3'd1,   // memory strobe for the CPU access
        ST_CPU_LAT  = 3'd2,   // memory read latency; DTACKn is asserted here
        ST_CPU_HOLD = 3'd3,   // hold DTACKn until the CPU drops AS
        ST_SPI_ACC  = 3'd4,   // memory strobe for the SPI access
        ST_SPI_LAT  = 3'd5    // memory read latency; ack is issued here
    } state_t;

    localparam logic [7:0] STARVE_LIMIT = 8'(SPI_STARVE_LIMIT);
    localparam logic [7:0] STARVE_MAX   = 8'hFF;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                 r_state;
    logic [7:0]             r_starve_cnt;
    logic                   r_cpu_rd;      // current CPU access is a read

    logic [15:0]            r_cpu_din;
    logic                   r_cpu_dtack_n;
    logic                   r_spi_ack;
    logic [15:0]            r_spi_rdata;

    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic                   r_mem_we;
    logic                   r_mem_re;
    logic [1:0]             r_mem_be;
    logic [15:0]            r_mem_wdata;

`ifdef MEM_ARB_SPI_READ_EN
    logic                   r_spi_rd;      // current SPI access is a read
`endif

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t                 w_next_state;
    logic                   w_cpu_pend;
    logic                   w_spi_starved;
    logic                   w_spi_waiting;
    logic                   w_grant_cpu;
    logic                   w_grant_spi;

    // A CPU cycle is pending only while DTACKn is still high. This stops the
    // access that is being held in CPU_HOLD from being counted as a new one.
    assign w_cpu_pend    = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n) & r_cpu_dtack_n;
    assign w_spi_starved = (r_starve_cnt >= STARVE_LIMIT);

    // The SPI requester is only "waiting" while it is not being served.
    assign w_spi_waiting = spi_req &&
                           (r_state != ST_SPI_ACC) && (r_state != ST_SPI_LAT);

    // -------------------------------------------------------------------------
    // Next-state and grant decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first. A path that does not assign
        // a signal would otherwise infer a latch.
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_spi  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cpu_pend && spi_req) begin
                    // Both want the memory. The CPU wins unless SPI has
                    // waited long enough.
                    if (w_spi_starved) begin
                        w_grant_spi = 1'b1;
                    end else begin
                        w_grant_cpu = 1'b1;
                    end
                end else if (w_cpu_pend) begin
                    w_grant_cpu = 1'b1;
                end else if (spi_req) begin
                    w_grant_spi = 1'b1;
                end

                if (w_grant_cpu) begin
                    w_next_state = ST_CPU_ACC;
                end else if (w_grant_spi) begin
                    w_next_state = ST_SPI_ACC;
                end
            end

            ST_CPU_ACC:  w_next_state = ST_CPU_LAT;
            ST_CPU_LAT:  w_next_state = ST_CPU_HOLD;

            ST_CPU_HOLD: begin
                if (cpu_as_n) begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_SPI_ACC:  w_next_state = ST_SPI_LAT;
            ST_SPI_LAT:  w_next_state = ST_IDLE;

            default:     w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together at the edge, whatever order the
        // blocks are evaluated in.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Memory command
    // The command is launched on the grant edge, so the strobes are high for
    // exactly the one cycle spent in the ACC state. Address, byte enables and
    // data keep their value afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_be    <= 2'b00;
            r_mem_wdata <= 16'h0000;
            r_cpu_rd    <= 1'b0;
`ifdef MEM_ARB_SPI_READ_EN
            r_spi_rd    <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;

            if (w_grant_cpu) begin
                r_mem_addr  <= cpu_a;
                r_mem_be    <= {~cpu_uds_n, ~cpu_lds_n};
                r_mem_wdata <= cpu_dout;
                r_mem_re    <= cpu_rw;
                r_mem_we    <= ~cpu_rw;
                r_cpu_rd    <= cpu_rw;
            end else if (w_grant_spi) begin
                r_mem_addr  <= spi_addr;
                r_mem_be    <= 2'b11;
                r_mem_wdata <= spi_wdata;
                r_mem_we    <= spi_we;
`ifdef MEM_ARB_SPI_READ_EN
                r_mem_re    <= ~spi_we;
                r_spi_rd    <= ~spi_we;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU response: read data capture and DTACKn
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_din     <= 16'h0000;
            r_cpu_dtack_n <= 1'b1;
        end else begin
            if (r_state == ST_CPU_LAT) begin
                // mem_rdata is valid in this cycle, one cycle after mem_re.
                if (r_cpu_rd) begin
                    r_cpu_din <= mem_rdata;
                end
                r_cpu_dtack_n <= 1'b0;
            end else if ((r_state == ST_CPU_HOLD) && cpu_as_n) begin
                r_cpu_dtack_n <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // SPI response: completion pulse and read data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_ack <= 1'b0;
        end else begin
            r_spi_ack <= (r_state == ST_SPI_LAT);
        end
    end

`ifdef MEM_ARB_SPI_READ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_rdata <= 16'h0000;
        end else if ((r_state == ST_SPI_LAT) && r_spi_rd) begin
            r_spi_rdata <= mem_rdata;
        end
    end
`else
    // Without the read path, spi_rdata is permanently zero.
    always_ff @(posedge clk) begin
        r_spi_rdata <= 16'h0000;
    end
`endif

    // -------------------------------------------------------------------------
    // Starvation counter
    // The counter clears when SPI is granted. It saturates at its maximum, so
    // a long wait can never wrap back to a small value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
        end else if (w_grant_spi) begin
            r_starve_cnt <= 8'd0;
        end else if (w_spi_waiting && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cpu_din     = r_cpu_din;
    assign cpu_dtack_n = r_cpu_dtack_n;
    assign spi_ack     = r_spi_ack;
    assign spi_rdata   = r_spi_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_re      = r_mem_re;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;

endmodule
